// File: rtl/calc_pkg.sv
// Shared types and widths for the calculator request issuer and its tag pool.
package calc_pkg;

    localparam int unsigned NTAGS  = 4;
    localparam int unsigned TAG_W  = 2;
    localparam int unsigned CMD_W  = 4;
    localparam int unsigned RESP_W = 2;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [CMD_W-1:0] {
        CMD_NOP = 4'd0,
        CMD_ADD = 4'd1,
        CMD_SUB = 4'd2,
        CMD_SHL = 4'd5,
        CMD_SHR = 4'd6
    } cmd_e;

    typedef enum logic [RESP_W-1:0] {
        RESP_NONE    = 2'd0,
        RESP_OK      = 2'd1,
        RESP_OVF     = 2'd2,
        RESP_INVALID = 2'd3
    } resp_e;

    typedef logic [TAG_W-1:0] tag_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OP2  = 1'b1
    } state_e;

    // One beat on the DUT request port.
    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [DATA_W-1:0] data;
        tag_t              tag;
    } dut_req_t;

    // One completion report towards the consumer.
    typedef struct packed {
        logic              valid;
        tag_t              tag;
        logic [CMD_W-1:0]  cmd;
        logic [RESP_W-1:0] code;
        logic [DATA_W-1:0] data;
        logic              timeout;
    } rsp_t;

    // Index of the lowest set bit; 0 when none is set (callers qualify with |v).
    function automatic tag_t lowest_set(input logic [NTAGS-1:0] v);
        tag_t t;
        t = '0;
        for (int i = NTAGS - 1; i >= 0; i--) begin
            if (v[i]) t = TAG_W'(i);
        end
        return t;
    endfunction

endpackage

// File: rtl/calc_tag_pool.sv
// Busy mask for the outstanding DUT tags with lowest-free allocation.
module calc_tag_pool
    import calc_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             alloc,
    input  logic             free,
    input  logic [TAG_W-1:0] free_tag,
    output logic [NTAGS-1:0] busy,
    output logic [TAG_W-1:0] alloc_tag_c,
    output logic             full_c
);

    logic [NTAGS-1:0] set_mask;
    logic [NTAGS-1:0] clr_mask;

    assign alloc_tag_c = lowest_set(~busy);
    assign full_c      = &busy;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (alloc) set_mask[alloc_tag_c] = 1'b1;
        if (free)  clr_mask[free_tag]    = 1'b1;
    end

    // Alloc and free never hit the same tag: only free tags are allocated, only busy ones freed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy <= '0;
        end else begin
            busy <= (busy | set_mask) & ~clr_mask;
        end
    end

endmodule

// File: rtl/calc_req_issuer.sv
// Issues tagged two-beat commands to one calculator DUT port and reports completions or timeouts.
module calc_req_issuer
    import calc_pkg::*;
#(
    parameter int unsigned TIMEOUT = 100
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_cmd,
    input  logic [31:0] in_op1,
    input  logic [31:0] in_op2,
    output logic [3:0]  dut_cmd,
    output logic [31:0] dut_data,
    output logic [1:0]  dut_tag,
    input  logic [1:0]  dut_resp,
    input  logic [31:0] dut_rdata,
    input  logic [1:0]  dut_rtag,
    output logic        rsp_valid,
    output logic [1:0]  rsp_tag,
    output logic [3:0]  rsp_cmd,
    output logic [1:0]  rsp_code,
    output logic [31:0] rsp_data,
    output logic        rsp_timeout,
    output logic        spurious
);

    localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    state_e            state_q, state_d;
    tag_t              cur_tag_q;
    dut_req_t          req_q, req_d;
    rsp_t              rsp_q, rsp_d;
    logic              spurious_q;

    logic [CMD_W-1:0]  cmd_tab_q [NTAGS];
    logic [DATA_W-1:0] op2_tab_q [NTAGS];
    logic [CNT_W-1:0]  cnt_q     [NTAGS];

    logic [NTAGS-1:0]  busy;
    tag_t              alloc_tag_c;
    logic              full_c;
    logic              accept_c;
    logic              resp_hit_c;
    logic              spur_c;
    logic [NTAGS-1:0]  expired_c;
    tag_t              exp_tag_c;
    logic              any_exp_c;
    logic              free_c;
    tag_t              free_tag_c;

    // Ready is forced low while reset is held, even though the state already reads IDLE.
    assign in_ready   = reset_n && (state_q == ST_IDLE) && !full_c;
    assign accept_c   = in_valid && in_ready;
    assign resp_hit_c = (dut_resp != RESP_NONE) && busy[dut_rtag];
    assign spur_c     = (dut_resp != RESP_NONE) && !busy[dut_rtag];
    assign exp_tag_c  = lowest_set(expired_c);
    assign any_exp_c  = |expired_c;
    assign free_c     = resp_hit_c || any_exp_c;
    assign free_tag_c = resp_hit_c ? dut_rtag : exp_tag_c;

    calc_tag_pool u_pool (
        .clk         (clk),
        .reset_n     (reset_n),
        .alloc       (accept_c),
        .free        (free_c),
        .free_tag    (free_tag_c),
        .busy        (busy),
        .alloc_tag_c (alloc_tag_c),
        .full_c      (full_c)
    );

    always_comb begin
        expired_c = '0;
        for (int i = 0; i < NTAGS; i++) begin
            expired_c[i] = busy[i] && (cnt_q[i] == CNT_W'(TIMEOUT));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request sequencing: cmd beat follows the accept, op2 beat follows the cmd beat.
    always_comb begin
        state_d = state_q;
        req_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    state_d    = ST_OP2;
                    req_d.cmd  = in_cmd;
                    req_d.data = in_op1;
                    req_d.tag  = alloc_tag_c;
                end
            end
            ST_OP2: begin
                state_d    = ST_IDLE;
                req_d.data = op2_tab_q[cur_tag_q];
                req_d.tag  = cur_tag_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A DUT response wins over any pending timeout; expired tags drain one per cycle.
    always_comb begin
        rsp_d = '0;
        if (resp_hit_c) begin
            rsp_d.valid = 1'b1;
            rsp_d.tag   = dut_rtag;
            rsp_d.cmd   = cmd_tab_q[dut_rtag];
            rsp_d.code  = dut_resp;
            rsp_d.data  = dut_rdata;
        end else if (any_exp_c) begin
            rsp_d.valid   = 1'b1;
            rsp_d.tag     = exp_tag_c;
            rsp_d.cmd     = cmd_tab_q[exp_tag_c];
            rsp_d.timeout = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_q      <= '0;
            rsp_q      <= '0;
            spurious_q <= 1'b0;
            cur_tag_q  <= '0;
        end else begin
            req_q      <= req_d;
            rsp_q      <= rsp_d;
            spurious_q <= spur_c;
            if (accept_c) cur_tag_q <= alloc_tag_c;
        end
    end

    // Counters restart on allocation and again on the op2 beat, so a reused tag never inherits an old count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NTAGS; i++) begin
                cmd_tab_q[i] <= '0;
                op2_tab_q[i] <= '0;
                cnt_q[i]     <= '0;
            end
        end else begin
            for (int i = 0; i < NTAGS; i++) begin
                if (accept_c && (alloc_tag_c == TAG_W'(i))) begin
                    cmd_tab_q[i] <= in_cmd;
                    op2_tab_q[i] <= in_op2;
                end
                if ((accept_c && (alloc_tag_c == TAG_W'(i))) ||
                    ((state_q == ST_OP2) && (cur_tag_q == TAG_W'(i)))) begin
                    cnt_q[i] <= '0;
                end else if (busy[i] && (cnt_q[i] != CNT_W'(TIMEOUT))) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign dut_cmd     = req_q.cmd;
    assign dut_data    = req_q.data;
    assign dut_tag     = req_q.tag;
    assign rsp_valid   = rsp_q.valid;
    assign rsp_tag     = rsp_q.tag;
    assign rsp_cmd     = rsp_q.cmd;
    assign rsp_code    = rsp_q.code;
    assign rsp_data    = rsp_q.data;
    assign rsp_timeout = rsp_q.timeout;
    assign spurious    = spurious_q;

endmodule

// File: tb/tb_calc_req_issuer.sv
// Directed bench for calc_req_issuer with TIMEOUT=10 and hand-computed cycle-exact expectations.
module tb_calc_req_issuer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_cmd;
    logic [31:0] in_op1;
    logic [31:0] in_op2;
    logic [3:0]  dut_cmd;
    logic [31:0] dut_data;
    logic [1:0]  dut_tag;
    logic [1:0]  dut_resp;
    logic [31:0] dut_rdata;
    logic [1:0]  dut_rtag;
    logic        rsp_valid;
    logic [1:0]  rsp_tag;
    logic [3:0]  rsp_cmd;
    logic [1:0]  rsp_code;
    logic [31:0] rsp_data;
    logic        rsp_timeout;
    logic        spurious;

    int n_total = 0;
    int n_bad   = 0;

    logic [3:0] cmd_set [4] = '{4'd1, 4'd2, 4'd5, 4'd6};
    logic [1:0] order   [4] = '{2'd3, 2'd1, 2'd0, 2'd2};

    always #5 clk = ~clk;

    calc_req_issuer #(.TIMEOUT(10)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_cmd      (in_cmd),
        .in_op1      (in_op1),
        .in_op2      (in_op2),
        .dut_cmd     (dut_cmd),
        .dut_data    (dut_data),
        .dut_tag     (dut_tag),
        .dut_resp    (dut_resp),
        .dut_rdata   (dut_rdata),
        .dut_rtag    (dut_rtag),
        .rsp_valid   (rsp_valid),
        .rsp_tag     (rsp_tag),
        .rsp_cmd     (rsp_cmd),
        .rsp_code    (rsp_code),
        .rsp_data    (rsp_data),
        .rsp_timeout (rsp_timeout),
        .spurious    (spurious)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_req(input string tag, input logic [3:0] c, input logic [31:0] d,
                             input logic [1:0] t);
        check_eq({tag, ".cmd"},  64'(dut_cmd),  64'(c));
        check_eq({tag, ".data"}, 64'(dut_data), 64'(d));
        check_eq({tag, ".tag"},  64'(dut_tag),  64'(t));
    endtask

    task automatic check_rsp(input string tag, input logic v, input logic [1:0] t,
                             input logic [3:0] c, input logic [1:0] code,
                             input logic [31:0] d, input logic to);
        check_eq({tag, ".valid"},   64'(rsp_valid),   64'(v));
        check_eq({tag, ".tag"},     64'(rsp_tag),     64'(t));
        check_eq({tag, ".cmd"},     64'(rsp_cmd),     64'(c));
        check_eq({tag, ".code"},    64'(rsp_code),    64'(code));
        check_eq({tag, ".data"},    64'(rsp_data),    64'(d));
        check_eq({tag, ".timeout"}, 64'(rsp_timeout), 64'(to));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        in_cmd   = c;
        in_op1   = a;
        in_op2   = b;
    endtask

    task automatic drive_resp(input logic [1:0] code, input logic [31:0] d, input logic [1:0] t);
        dut_resp  = code;
        dut_rdata = d;
        dut_rtag  = t;
    endtask

    // Issues four commands back to back; leaves the bench in the op2 cycle of tag 3.
    task automatic issue_four(input string tag, input logic [31:0] base);
        for (int i = 0; i < 4; i++) begin
            drive_cmd(cmd_set[i], base + 32'(i), base + 32'h100 + 32'(i));
            step();
            in_valid = 1'b0;
            check_req({tag, ".c"}, cmd_set[i], base + 32'(i), 2'(i));
            step();
            check_req({tag, ".o"}, 4'd0, base + 32'h100 + 32'(i), 2'(i));
        end
    endtask

    int n_rsp;
    int rsp_cyc;
    logic [1:0] seen_tag;
    logic seen_to;

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_cmd   = '0;
        in_op1   = '0;
        in_op2   = '0;
        drive_resp(2'd0, 32'd0, 2'd0);
        step();
        step();
        check_req("rst", 4'd0, 32'd0, 2'd0);
        check_rsp("rst", 1'b0, 2'd0, 4'd0, 2'd0, 32'd0, 1'b0);
        check_eq("rst.ready", 64'(in_ready), 64'(0));
        check_eq("rst.spur", 64'(spurious), 64'(0));
        reset_n = 1'b1;
        #1;
        check_eq("rel.ready", 64'(in_ready), 64'(1));

        // Single ADD round trip
        drive_cmd(4'd1, 32'd5, 32'd7);
        step();
        in_valid = 1'b0;
        check_req("add.c", 4'd1, 32'd5, 2'd0);
        check_eq("add.op2_ready", 64'(in_ready), 64'(0));
        step();
        check_req("add.o", 4'd0, 32'd7, 2'd0);
        step();
        check_req("add.idle", 4'd0, 32'd0, 2'd0);
        drive_resp(2'd1, 32'd12, 2'd0);
        step();
        drive_resp(2'd0, 32'd0, 2'd0);
        check_rsp("add.rsp", 1'b1, 2'd0, 4'd1, 2'd1, 32'd12, 1'b0);
        step();
        check_rsp("add.end", 1'b0, 2'd0, 4'd0, 2'd0, 32'd0, 1'b0);

        // Spurious response while only tag 0 is busy
        drive_cmd(4'd2, 32'h10, 32'h3);
        step();
        in_valid = 1'b0;
        check_req("spur.c", 4'd2, 32'h10, 2'd0);
        step();
        drive_resp(2'd1, 32'hdead, 2'd1);
        step();
        drive_resp(2'd0, 32'd0, 2'd0);
        check_eq("spur.pulse", 64'(spurious), 64'(1));
        check_rsp("spur.norsp", 1'b0, 2'd0, 4'd0, 2'd0, 32'd0, 1'b0);
        drive_cmd(4'd6, 32'h20, 32'h4);
        step();
        in_valid = 1'b0;
        check_req("spur.next", 4'd6, 32'h20, 2'd1);
        check_eq("spur.pulse_end", 64'(spurious), 64'(0));
        drive_resp(2'd1, 32'h13, 2'd0);
        step();
        check_req("spur.next_o", 4'd0, 32'h4, 2'd1);
        check_rsp("spur.t0", 1'b1, 2'd0, 4'd2, 2'd1, 32'h13, 1'b0);
        drive_resp(2'd2, 32'h40, 2'd1);
        step();
        drive_resp(2'd0, 32'd0, 2'd0);
        check_rsp("spur.t1", 1'b1, 2'd1, 4'd6, 2'd2, 32'h40, 1'b0);
        check_eq("spur.quiet", 64'(spurious), 64'(0));
        step();
        check_rsp("spur.end", 1'b0, 2'd0, 4'd0, 2'd0, 32'd0, 1'b0);

        // Out-of-order completions 3,1,0,2
        issue_four("ooo", 32'h1000);
        for (int k = 0; k < 4; k++) begin
            drive_resp(2'd1, 32'h7000 + 32'(order[k]), order[k]);
            step();
            check_rsp("ooo.rsp", 1'b1, order[k], cmd_set[order[k]], 2'd1,
                      32'h7000 + 32'(order[k]), 1'b0);
        end
        drive_resp(2'd0, 32'd0, 2'd0);
        step();
        check_rsp("ooo.end", 1'b0, 2'd0, 4'd0, 2'd0, 32'd0, 1'b0);

        // Fill all four tags, hold a fifth, then drain via responses and timeouts
        issue_four("fill", 32'h2000);
        check_eq("fill.full", 64'(in_ready), 64'(0));
        drive_cmd(4'hf, 32'h500, 32'h600);
        step();
        check_eq("fill.held", 64'(in_ready), 64'(0));
        check_req("fill.noissue", 4'd0, 32'd0, 2'd0);
        drive_resp(2'd1, 32'h77, 2'd2);
        step();
        drive_resp(2'd0, 32'd0, 2'd0);
        check_rsp("fill.rsp2", 1'b1, 2'd2, 4'd5, 2'd1, 32'h77, 1'b0);
        check_eq("fill.reopen", 64'(in_ready), 64'(1));
        step();
        in_valid = 1'b0;
        check_req("fill.reissue", 4'hf, 32'h500, 2'd2);
        step();
        check_req("fill.reissue_o", 4'd0, 32'h600, 2'd2);
        drive_resp(2'd3, 32'h0bad, 2'd2);
        step();
        drive_resp(2'd0, 32'd0, 2'd0);
        check_rsp("to.resp_first", 1'b1, 2'd2, 4'hf, 2'd3, 32'h0bad, 1'b0);
        step();
        check_rsp("to.tag0", 1'b1, 2'd0, 4'd1, 2'd0, 32'd0, 1'b1);
        step();
        check_rsp("to.tag1", 1'b1, 2'd1, 4'd2, 2'd0, 32'd0, 1'b1);
        step();
        check_rsp("to.gap", 1'b0, 2'd0, 4'd0, 2'd0, 32'd0, 1'b0);
        step();
        check_rsp("to.gap2", 1'b0, 2'd0, 4'd0, 2'd0, 32'd0, 1'b0);
        step();
        drive_resp(2'd2, 32'h99, 2'd3);
        step();
        drive_resp(2'd0, 32'd0, 2'd0);
        check_rsp("to.expired_resp", 1'b1, 2'd3, 4'd6, 2'd2, 32'h99, 1'b0);
        step();
        check_rsp("to.drained", 1'b0, 2'd0, 4'd0, 2'd0, 32'd0, 1'b0);

        // Reset while a command sits in its cmd beat with three tags busy
        for (int i = 0; i < 3; i++) begin
            drive_cmd(4'd1, 32'h3000 + 32'(i), 32'h3100 + 32'(i));
            step();
            in_valid = 1'b0;
            if (i < 2) step();
        end
        check_req("rm.c", 4'd1, 32'h3002, 2'd2);
        reset_n = 1'b0;
        #1;
        check_req("rm.rst", 4'd0, 32'd0, 2'd0);
        check_rsp("rm.rst", 1'b0, 2'd0, 4'd0, 2'd0, 32'd0, 1'b0);
        check_eq("rm.ready", 64'(in_ready), 64'(0));
        step();
        step();
        reset_n = 1'b1;
        drive_cmd(4'd5, 32'h900, 32'h901);
        step();
        in_valid = 1'b0;
        check_req("rm.new", 4'd5, 32'h900, 2'd0);
        n_rsp    = 0;
        rsp_cyc  = 0;
        seen_tag = '0;
        seen_to  = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            step();
            if (rsp_valid) begin
                n_rsp++;
                rsp_cyc  = j;
                seen_tag = rsp_tag;
                seen_to  = rsp_timeout;
            end
        end
        check_eq("rm.count", 64'(n_rsp), 64'(1));
        check_eq("rm.tag", 64'(seen_tag), 64'(0));
        check_eq("rm.timeout", 64'(seen_to), 64'(1));
        check_eq("rm.when", 64'(rsp_cyc), 64'(12));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
